data_unalign: RTL and testbench

//  Transmit-side counterpart of the data aligner. Takes packets whose bytes are packed

---
 rtl/data_unalign_if.sv | 14 +
 rtl/data_unalign.sv | 154 +++++++++++++++
 tb/tb_data_unalign.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_unalign_if.sv
// Byte-lane stream bundle used on both sides of data_unalign.
// One beat carries DATA_BYTES bytes with per-byte enables and an end-of-packet flag.
interface data_unalign_if #(
    parameter int DATA_BYTES = 4
) ();
    logic                    valid;
    logic                    ready;
    logic [8*DATA_BYTES-1:0] data;
    logic [DATA_BYTES-1:0]   keep;
    logic                    last;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/data_unalign.sv
// data_unalign: re-emits lane-0-packed packets starting at a programmable byte lane.
// Bytes pushed past the top lane are carried into the next beat; when the last input
// beat spills, one extra flush beat carries the tail out.
// Optional feature: define DATA_UNALIGN_STAT_EN to add pkt_cnt_o / flush_cnt_o counters.
module data_unalign #(
    parameter int DATA_BYTES = 4,
    parameter int OFF_W      = $clog2(DATA_BYTES)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [OFF_W-1:0] offset_i,
    data_unalign_if.slave    s,
    data_unalign_if.master   m
`ifdef DATA_UNALIGN_STAT_EN
    ,
    output logic [31:0]      pkt_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);
    localparam int N     = DATA_BYTES;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [1:0] {ST_FIRST, ST_MID, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [8*N-1:0]   carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [8*N-1:0]   m_data_q, m_data_d;
    logic [N-1:0]     m_keep_q, m_keep_d;

    logic             out_free;
    logic             s_ready;
    logic             s_accept;
    logic             flush_emit;
    logic [OFF_W-1:0] off_eff;
    logic [8*N-1:0]   carry_lanes;
    logic [N-1:0]     carry_keep;
    logic [N-1:0]     keep_one;
    int               off_int;
    int               spill_int;

    assign keep_one   = N'(1);
    // The output register may take a new beat when empty or being drained this cycle.
    assign out_free   = !m_valid_q || m.ready;
    assign s_ready    = out_free && (state_q != ST_FLUSH);
    assign s_accept   = s.valid && s_ready;
    assign flush_emit = (state_q == ST_FLUSH) && out_free;

    assign s.ready = s_ready;
    assign m.valid = m_valid_q;
    assign m.data  = m_data_q;
    assign m.keep  = m_keep_q;
    assign m.last  = m_last_q;

    // Next-state and output-register load: shift input up by O lanes, fill low lanes from carry.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        state_d   = state_q;
        off_d     = off_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q && !m.ready;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;

        // The offset is sampled only on a packet's first beat; mid-packet it comes from off_q.
        off_eff     = (state_q == ST_FIRST) ? offset_i : off_q;
        off_int     = int'(off_eff);
        // Bytes of this beat that land beyond the top lane.
        spill_int   = $countones(s.keep) - (N - off_int);
        carry_lanes = (state_q == ST_FIRST) ? '0 : carry_q;
        carry_keep  = (state_q == ST_FIRST) ? '0 : ((keep_one << off_int) - keep_one);

        if (s_accept) begin
            m_valid_d = 1'b1;
            m_data_d  = (s.data << (8 * off_int)) | carry_lanes;
            m_keep_d  = (s.keep << off_int) | carry_keep;
            m_last_d  = 1'b0;
            off_d     = off_eff;
            // Shift by the full width when O = 0 yields zero: nothing is carried.
            carry_d   = s.data >> (8 * (N - off_int));
            cnt_d     = '0;
            if (!s.last) begin
                state_d = ST_MID;
            end else if (spill_int > 0) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_W'(spill_int);
            end else begin
                state_d  = ST_FIRST;
                m_last_d = 1'b1;
                carry_d  = '0;
            end
        end else if (flush_emit) begin
            m_valid_d = 1'b1;
            m_data_d  = carry_q;
            m_keep_d  = (keep_one << cnt_q) - keep_one;
            m_last_d  = 1'b1;
            carry_d   = '0;
            cnt_d     = '0;
            state_d   = ST_FIRST;
        end
    end

    // State, carry and output register; reset discards any packet in flight.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_FIRST;
            off_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            state_q   <= state_d;
            off_q     <= off_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
        end
    end

`ifdef DATA_UNALIGN_STAT_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] flush_cnt_q;

    // Count completed packets on the output and flush beats loaded; both wrap naturally.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_valid_q && m.ready && m_last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (flush_emit) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_data_unalign.sv
// Self-checking bench for data_unalign (DATA_BYTES = 4).
// Expected output beats come from placing the packet's bytes at absolute stream
// positions O .. O+len-1 and cutting that stream into 4-byte beats.
`timescale 1ns/1ps
module tb_data_unalign;
    localparam int N = 4;

    typedef struct {
        logic [8*N-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
        logic           first;
        logic [1:0]     off;
        logic           spill;
    } in_beat_t;

    typedef struct {
        logic [8*N-1:0] data;
        logic [N-1:0]   keep;
        logic           last;
    } out_beat_t;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [1:0] offset_i;

    data_unalign_if #(.DATA_BYTES(N)) s_if ();
    data_unalign_if #(.DATA_BYTES(N)) m_if ();

`ifdef DATA_UNALIGN_STAT_EN
    logic [31:0] pkt_cnt;
    logic [31:0] flush_cnt;
`endif

    data_unalign #(.DATA_BYTES(N)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .offset_i (offset_i),
        .s        (s_if),
        .m        (m_if)
`ifdef DATA_UNALIGN_STAT_EN
        ,
        .pkt_cnt_o   (pkt_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int        total = 0;
    int        bad   = 0;
    in_beat_t  drv_q[$];
    out_beat_t exp_q[$];
    bit        presenting;
    bit        prev_s_hs;
    bit        prev_spill;
    bit        prev_stall;
    logic [8*N-1:0] prev_data;
    logic [N-1:0]   prev_keep;
    logic           prev_last;
    int        ready_pct;
    bit        gaps;
    int        n_pkts;
    int        n_spill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build input beats and the expected output beats for one packet.
    task automatic queue_pkt(input int off, input int len, input bit rnd);
        byte unsigned b[];
        int           nb_in;
        int           nb_out;
        int           pos;
        in_beat_t     ib;
        out_beat_t    ob;
        b = new[len];
        for (int i = 0; i < len; i++) b[i] = rnd ? 8'($urandom) : 8'(i);
        nb_in  = (len + N - 1) / N;
        nb_out = (off + len + N - 1) / N;
        for (int k = 0; k < nb_in; k++) begin
            ib.data = '0;
            ib.keep = '0;
            for (int j = 0; j < N; j++) begin
                if (k * N + j < len) begin
                    ib.keep[j]        = 1'b1;
                    ib.data[8*j +: 8] = b[k*N + j];
                end
            end
            ib.last  = (k == nb_in - 1);
            ib.first = (k == 0);
            ib.off   = 2'(off);
            ib.spill = ib.last && (nb_out > nb_in);
            drv_q.push_back(ib);
        end
        for (int k = 0; k < nb_out; k++) begin
            ob.data = '0;
            ob.keep = '0;
            for (int j = 0; j < N; j++) begin
                pos = k * N + j;
                if (pos >= off && pos < off + len) begin
                    ob.keep[j]        = 1'b1;
                    ob.data[8*j +: 8] = b[pos - off];
                end
            end
            ob.last = (k == nb_out - 1);
            exp_q.push_back(ob);
        end
        n_pkts++;
        if (nb_out > nb_in) n_spill++;
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, handshakes resolve at the next rising edge.
    task automatic step();
        in_beat_t       cur;
        out_beat_t      eb;
        logic [8*N-1:0] emask;
        bit             s_hs;
        @(negedge clk);
        m_if.ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (!presenting && drv_q.size() > 0) presenting = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (presenting) begin
            cur         = drv_q[0];
            s_if.valid  = 1'b1;
            s_if.data   = cur.data;
            s_if.keep   = cur.keep;
            s_if.last   = cur.last;
            offset_i    = cur.first ? cur.off : 2'($urandom);
        end else begin
            s_if.valid  = 1'b0;
            s_if.data   = $urandom;
            s_if.keep   = '0;
            s_if.last   = 1'b0;
            offset_i    = 2'($urandom);
        end
        #1;
        if (prev_s_hs) begin
            check("latency", 64'(m_if.valid), 64'd1);
            if (prev_spill) check("flush_s_ready", 64'(s_if.ready), 64'd0);
            else if (m_if.ready) check("no_flush_s_ready", 64'(s_if.ready), 64'd1);
        end
        if (prev_stall) begin
            check("hold_ctl", 64'({m_if.valid, m_if.last, m_if.keep}), 64'({1'b1, prev_last, prev_keep}));
            check("hold_data", 64'(m_if.data), 64'(prev_data));
        end
        if (m_if.valid && m_if.ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'(m_if.valid && m_if.ready), 64'd0);
            end else begin
                eb    = exp_q.pop_front();
                emask = '0;
                for (int j = 0; j < N; j++) if (eb.keep[j]) emask[8*j +: 8] = 8'hff;
                check("out_keep", 64'(m_if.keep), 64'(eb.keep));
                check("out_last", 64'(m_if.last), 64'(eb.last));
                check("out_data", 64'(m_if.data & emask), 64'(eb.data));
            end
            prev_stall = 1'b0;
        end else begin
            prev_stall = m_if.valid;
        end
        prev_data  = m_if.data;
        prev_keep  = m_if.keep;
        prev_last  = m_if.last;
        s_hs       = s_if.valid && s_if.ready;
        prev_s_hs  = s_hs;
        prev_spill = s_hs && presenting && cur.spill;
        if (s_hs) begin
            void'(drv_q.pop_front());
            presenting = 1'b0;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        while ((drv_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", 64'(drv_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        aresetn    = 1'b0;
        s_if.valid = 1'b0;
        s_if.keep  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b1;
        drv_q.delete();
        exp_q.delete();
        presenting = 1'b0;
        prev_s_hs  = 1'b0;
        prev_spill = 1'b0;
        prev_stall = 1'b0;
        n_pkts     = 0;
        n_spill    = 0;
        #1;
        check("rst_valid", 64'(m_if.valid), 64'd0);
        check("rst_last", 64'(m_if.last), 64'd0);
        check("rst_keep", 64'(m_if.keep), 64'd0);
        check("rst_data", 64'(m_if.data), 64'd0);
`ifdef DATA_UNALIGN_STAT_EN
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        int c;
        aresetn    = 1'b0;
        offset_i   = '0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
        ready_pct  = 100;
        gaps       = 1'b0;
        apply_reset();

        // O=1, two full beats -> three output beats with a flush.
        queue_pkt(1, 8, 1'b0);
        run_until_idle(50);
        // O=0 pass-through, 6 bytes.
        queue_pkt(0, 6, 1'b0);
        run_until_idle(50);
        // O=3, single byte into the top lane.
        queue_pkt(3, 1, 1'b0);
        run_until_idle(50);
        // O=2, 3 bytes -> spill into a flush beat.
        queue_pkt(2, 3, 1'b0);
        run_until_idle(50);
        // Back-to-back packets with no gaps.
        queue_pkt(0, 4, 1'b0);
        queue_pkt(3, 2, 1'b0);
        queue_pkt(1, 7, 1'b0);
        run_until_idle(100);

        // 100 random packets with output stalls and input gaps.
        apply_reset();
        ready_pct = 50;
        gaps      = 1'b1;
        for (int p = 0; p < 100; p++) queue_pkt(int'($urandom_range(0, 3)), int'($urandom_range(1, 16)), 1'b1);
        run_until_idle(20000);
        step();
`ifdef DATA_UNALIGN_STAT_EN
        check("pkt_cnt", 64'(pkt_cnt), 64'(n_pkts));
        check("flush_cnt", 64'(flush_cnt), 64'(n_spill));
`endif

        // Reset after the first beat of a 3-beat packet, then a clean packet with a new offset.
        ready_pct = 100;
        gaps      = 1'b0;
        queue_pkt(1, 12, 1'b0);
        c = 0;
        while (drv_q.size() > 2 && c < 20) begin
            step();
            c++;
        end
        check("t6_first_beat_taken", 64'(drv_q.size()), 64'd2);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_idle", 64'(m_if.valid), 64'd0);
        end
        queue_pkt(3, 5, 1'b0);
        run_until_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
